rgb_pwm_led: RTL and testbench
==============================

// Module: rgb_pwm_led
// PURPOSE
//   PWM output stage for the on-board RGB LED. Takes 8-bit-per-channel colour words over a
//   valid/ready handshake and drives the 3-bit active-low LED pins with per-channel PWM.
//   Colour generators (rainbow sequencer, button-driven pickers) sit upstream and feed it.
//   It replaces fast toggling between base colours with true intermediate intensities.
// PARAMETERS
//   PWM_BITS  8   duty resolution; one frame = 2**PWM_BITS steps
//   DIV       47  clk cycles per PWM step (12 MHz / 47 / 256 = ~997 Hz frame rate); DIV >= 2
// PORTS
//   clk          in   1         system clock, 12 MHz
//   rst_n        in   1         asynchronous active-low reset (button_a)
//   color_valid  in   1         upstream colour word valid
//   color_ready  out  1         block can accept a colour word
//   color_r      in   PWM_BITS  red duty request
//   color_g      in   PWM_BITS  green duty request
//   color_b      in   PWM_BITS  blue duty request
//   brightness   in   PWM_BITS  global scale, sampled with the colour word
//   led          out  3         active-low LED pins: [2]=red, [1]=blue, [0]=green
//   frame_start  out  1         one-clk pulse at each PWM frame boundary
// BEHAVIOUR
//   Reset (async, rst_n low): led=3'b111 (all off), frame_start=0, pre_cnt=0, step_cnt=0,
//     active duties=0, pending buffer empty; color_ready=1 (combinational from pend_full=0).
//   Prescaler: pre_cnt counts 0..DIV-1 and wraps; step_tick = (pre_cnt==DIV-1).
//   Step counter: step_cnt (PWM_BITS wide) increments on step_tick, wraps 2**PWM_BITS-1 -> 0.
//   Frame boundary: fb = step_tick && step_cnt==all-ones. frame_start registered, high the
//     cycle after fb (i.e. first clk of step 0), exactly once per frame.
//   Handshake: color_ready = !pend_full. Accept = color_valid && color_ready; on accept latch
//     pend_r/g/b = scaled values, set pend_full. Data must not change while valid && !ready.
//   Scaling on accept: duty_x = (color_x * (brightness + 1)) >> PWM_BITS, PWM_BITS+PWM_BITS+1
//     bit product, truncated; brightness=all-ones gives duty_x = color_x exactly.
//   Load: on fb, if pend_full: active <= pend, pend_full <= 0. If empty, active keeps value.
//   Same-cycle accept and fb with pend empty: word goes to pending, loaded at the NEXT fb.
//     Active duties never change mid-frame (no glitch/partial frame).
//   Output: each clk, led[ch] <= ~(step_cnt < active_ch) (registered, 1-clk lag from counters).
//     duty 0 -> channel never lit; duty 255 -> lit 255 of 256 steps (never 100%).
//   Latency: accept -> first lit step <= 1 frame + 2 clk (2**PWM_BITS*DIV + 2 clocks).
//   Throughput: at most one colour word per frame; upstream is back-pressured otherwise.
//   Reset mid-frame: all state cleared immediately, led forced 3'b111 asynchronously; pending
//     and active data discarded; restart from step 0 after release.
//   No other outputs; color_ready has no combinational path from color_valid.
// TESTING
//   1. Reset: hold rst_n=0 -> led=3'b111, frame_start=0, color_ready=1; release -> first
//      frame_start 12032 clk later (256*47), then every 12032 clk.
//   2. r=128,g=0,b=0,bright=255 accepted -> from next frame led[2]=0 for 6016 clk then 1 for
//      6016 clk; led[1:0] stay 2'b11.
//   3. Scaling: r=200, bright=127 -> duty 100 -> led[2] low 4700 clk per frame; r=255,
//      bright=0 -> duty 0 -> led[2] never low.
//   4. Back-pressure: present words A then B back to back -> A accepted, color_ready=0 until
//      fb; A active at that fb, B accepted cycle after, B active at following fb.
//   5. Accept on exact fb cycle with pending empty -> active unchanged this frame, loaded
//      one frame later; no mid-frame duty change observed on led.
//   6. Assert rst_n=0 mid-frame with led lit -> led=3'b111 same cycle, pending dropped,
//      counters restart at 0 after release.

Source files
------------

// File: rtl/rgb_pwm_led.sv
// PWM output stage for the RGB LED: accepts brightness-scaled colour words over valid/ready
// and drives three active-low LED pins, updating duties only on frame boundaries.
module rgb_pwm_led #(
    parameter int PWM_BITS = 8,
    parameter int DIV      = 47
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                color_valid,
    output logic                color_ready,
    input  logic [PWM_BITS-1:0] color_r,
    input  logic [PWM_BITS-1:0] color_g,
    input  logic [PWM_BITS-1:0] color_b,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [2:0]          led,
    output logic                frame_start
);

    localparam int                  PRE_W     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] STEP_LAST = {PWM_BITS{1'b1}};

    // brightness+1 lets full brightness pass the colour through unchanged
    function automatic logic [PWM_BITS-1:0] scale_duty(input logic [PWM_BITS-1:0] col,
                                                       input logic [PWM_BITS-1:0] bri);
        logic [2*PWM_BITS:0] prod;
        prod = (2*PWM_BITS+1)'(col) * ((2*PWM_BITS+1)'(bri) + (2*PWM_BITS+1)'(1));
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [PWM_BITS-1:0] step_cnt_r;
    logic                pend_full_r;
    logic [PWM_BITS-1:0] pend_red_r, pend_grn_r, pend_blu_r;
    logic [PWM_BITS-1:0] act_red_r, act_grn_r, act_blu_r;
    logic                step_tick_s;
    logic                fb_s;
    logic                accept_s;

    assign step_tick_s = (pre_cnt_r == PRE_LAST);
    assign fb_s        = step_tick_s && (step_cnt_r == STEP_LAST);
    assign color_ready = ~pend_full_r;
    assign accept_s    = color_valid && ~pend_full_r;

    // Prescaler and PWM step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r  <= '0;
            step_cnt_r <= '0;
        end else begin
            if (step_tick_s) begin
                pre_cnt_r  <= '0;
                step_cnt_r <= step_cnt_r + PWM_BITS'(1);
            end else begin
                pre_cnt_r  <= pre_cnt_r + PRE_W'(1);
            end
        end
    end

    // Pending buffer and active duties; active only changes at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_r <= 1'b0;
            pend_red_r  <= '0;
            pend_grn_r  <= '0;
            pend_blu_r  <= '0;
            act_red_r   <= '0;
            act_grn_r   <= '0;
            act_blu_r   <= '0;
        end else if (fb_s && pend_full_r) begin
            act_red_r   <= pend_red_r;
            act_grn_r   <= pend_grn_r;
            act_blu_r   <= pend_blu_r;
            pend_full_r <= 1'b0;
        end else if (accept_s) begin
            pend_red_r  <= scale_duty(color_r, brightness);
            pend_grn_r  <= scale_duty(color_g, brightness);
            pend_blu_r  <= scale_duty(color_b, brightness);
            pend_full_r <= 1'b1;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    // Registered pin drive: [2]=red, [1]=blue, [0]=green, low = lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led         <= 3'b111;
            frame_start <= 1'b0;
        end else begin
            led         <= {~(step_cnt_r < act_red_r),
                            ~(step_cnt_r < act_blu_r),
                            ~(step_cnt_r < act_grn_r)};
            frame_start <= fb_s;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_led.sv
// Self-checking bench for rgb_pwm_led: directed scenarios then random colour traffic,
// all compared every cycle against a frame-level timing model.
module tb_rgb_pwm_led;

    localparam int PB = 8;
    localparam int DV = 3;
    localparam int F  = (1 << PB) * DV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          color_valid = 1'b0;
    logic          color_ready;
    logic [PB-1:0] color_r = '0, color_g = '0, color_b = '0, brightness = '0;
    logic [2:0]    led;
    logic          frame_start;

    rgb_pwm_led #(.PWM_BITS(PB), .DIV(DV)) dut (
        .clk(clk), .rst_n(rst_n), .color_valid(color_valid), .color_ready(color_ready),
        .color_r(color_r), .color_g(color_g), .color_b(color_b), .brightness(brightness),
        .led(led), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int t;
    int m_act[3];
    int m_pend[3];
    bit m_full;
    bit last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, obs, exp_v, t);
        end
    endtask

    function automatic int scl(input int c, input int br);
        return (c * (br + 1)) >> PB;
    endfunction

    // Pin state after edge tt reflects the step reached after tt-1 elapsed clocks
    function automatic logic [2:0] exp_led(input int tt);
        int step;
        step = ((tt - 1) / DV) % (1 << PB);
        return {step >= m_act[0], step >= m_act[2], step >= m_act[1]};
    endfunction

    task automatic cyc(input bit v, input int r, input int g, input int b, input int br);
        logic [2:0] el;
        bit fb;
        bit acc;
        int rr, gg, bb, bri;
        rr = r; gg = g; bb = b; bri = br;
        color_valid = v;
        color_r = rr[PB-1:0];
        color_g = gg[PB-1:0];
        color_b = bb[PB-1:0];
        brightness = bri[PB-1:0];
        t++;
        el  = exp_led(t);
        fb  = (t % F == 0);
        acc = v && !m_full;
        if (fb && m_full) begin
            m_act  = m_pend;
            m_full = 1'b0;
        end
        if (acc) begin
            m_pend[0] = scl(r, br);
            m_pend[1] = scl(g, br);
            m_pend[2] = scl(b, br);
            m_full    = 1'b1;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("led", 32'(led), 32'(el));
        chk("frame_start", 32'(frame_start), 32'(fb));
        chk("color_ready", 32'(color_ready), 32'(!m_full));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0);
    endtask

    task automatic to_fb();
        while (t % F != 0) cyc(1'b0, 0, 0, 0, 0);
    endtask

    task automatic count_frame(input int pin, output int cnt);
        cnt = 0;
        for (int i = 0; i < F; i++) begin
            cyc(1'b0, 0, 0, 0, 0);
            if (led[pin] == 1'b0) cnt++;
        end
    endtask

    task automatic do_reset();
        color_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_led", 32'(led), 32'd7);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_ready", 32'(color_ready), 32'd1);
        m_full = 1'b0;
        m_act  = '{0, 0, 0};
        m_pend = '{0, 0, 0};
        t = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int guard;
        bit cur_v;
        int cr, cg, cb, cbr;

        // 1. reset and first frame boundary after F clocks
        #2;
        do_reset();
        idle(F);
        chk("first_fs_phase", 32'(t), 32'(F));

        // 2. red half duty
        cyc(1'b1, 128, 0, 0, 255);
        to_fb();
        count_frame(2, cnt);
        chk("red_half_cnt", 32'(cnt), 32'(128 * DV));

        // 3. scaling
        cyc(1'b1, 200, 0, 0, 127);
        to_fb();
        count_frame(2, cnt);
        chk("red_scaled_cnt", 32'(cnt), 32'(100 * DV));
        cyc(1'b1, 255, 0, 0, 0);
        to_fb();
        count_frame(2, cnt);
        chk("red_zero_cnt", 32'(cnt), 32'd0);

        // 4. back-to-back words A then B
        idle(10);
        cyc(1'b1, 40, 80, 120, 255);
        guard = 0;
        do begin
            cyc(1'b1, 10, 20, 30, 255);
            guard++;
        end while (!last_acc && guard < 2 * F);
        chk("b_accepted", 32'(last_acc), 32'd1);
        chk("b_accept_phase", 32'(t % F), 32'd1);
        to_fb();

        // 5. accept exactly on the frame-boundary cycle
        while ((t + 1) % F != 0) cyc(1'b0, 0, 0, 0, 0);
        cyc(1'b1, 0, 255, 0, 255);
        count_frame(0, cnt);
        chk("fb_accept_old_duty", 32'(cnt), 32'(20 * DV));
        count_frame(0, cnt);
        chk("fb_accept_new_duty", 32'(cnt), 32'(255 * DV));

        // 6. reset mid-frame with green lit and a word pending
        cyc(1'b1, 255, 255, 255, 255);
        idle(F / 4);
        chk("green_lit_pre_reset", 32'(led[0]), 32'd0);
        do_reset();
        idle(F + 10);

        // 7. random traffic
        cur_v = 1'b0;
        cr = 0; cg = 0; cb = 0; cbr = 0;
        for (int i = 0; i < 20 * F; i++) begin
            if (!cur_v && $urandom_range(0, 99) < 3) begin
                cur_v = 1'b1;
                cr  = $urandom_range(0, 255);
                cg  = $urandom_range(0, 255);
                cb  = $urandom_range(0, 255);
                cbr = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            end
            cyc(cur_v, cr, cg, cb, cbr);
            if (last_acc) cur_v = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
